// File: rtl/fetch_ctrl_if.sv
// Bundle of the loader, instruction-memory write and fetch-control signals
// of fetch_ctrl; master is the controller side.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              br_taken_e;
  logic [31:0]       br_target_e;
  logic              load_use_d;
  logic              halt_req;
  logic              boot_req;
  logic              stall;
  logic              pc_sel;
  logic [31:0]       pc_nxt;
  logic              flush_d;
  logic              flush_e;
  logic              boot_done;
  logic              err_misalign;
  logic              err_overflow;

  modport master (
    input  ld_valid, ld_data, ld_last, br_taken_e, br_target_e,
           load_use_d, halt_req, boot_req,
    output ld_ready, imem_we, imem_waddr, imem_wdata, stall, pc_sel,
           pc_nxt, flush_d, flush_e, boot_done, err_misalign, err_overflow
  );

  modport slave (
    output ld_valid, ld_data, ld_last, br_taken_e, br_target_e,
           load_use_d, halt_req, boot_req,
    input  ld_ready, imem_we, imem_waddr, imem_wdata, stall, pc_sel,
           pc_nxt, flush_d, flush_e, boot_done, err_misalign, err_overflow
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: loads the program image into instruction memory,
// releases the core at the boot PC, then drives stall/redirect/flush in run mode.
module fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] wcnt;
  logic              accept;
  logic              set_misalign;

  // Loader handshake is only open in BOOT, so acceptance depends on state alone.
  assign accept = bus.ld_valid & (state == BOOT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  // Next state and control outputs; RUN outputs follow the hazard inputs directly.
  always_comb begin
    state_nxt    = state;
    bus.ld_ready = 1'b0;
    bus.stall    = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.pc_nxt   = RESET_PC;
    bus.flush_d  = 1'b0;
    bus.flush_e  = 1'b0;
    set_misalign = 1'b0;
    case (state)
      BOOT: begin
        bus.ld_ready = 1'b1;
        bus.stall    = 1'b1;
        if (accept && (bus.ld_last || (wcnt == LAST_ADDR))) state_nxt = START;
      end
      START: begin
        bus.pc_sel  = 1'b1;
        bus.flush_d = 1'b1;
        bus.flush_e = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        bus.pc_nxt = bus.br_target_e;
        if (bus.br_taken_e && (bus.br_target_e[1:0] != 2'b00)) begin
          set_misalign = 1'b1;
          bus.stall    = 1'b1;
          bus.flush_d  = 1'b1;
          bus.flush_e  = 1'b1;
          state_nxt    = HALT;
        end else if (bus.br_taken_e) begin
          // A coincident load-use stall is dropped: its instruction is flushed.
          bus.pc_sel  = 1'b1;
          bus.flush_d = 1'b1;
          bus.flush_e = 1'b1;
        end else if (bus.halt_req) begin
          bus.stall   = 1'b1;
          bus.flush_d = 1'b1;
          state_nxt   = HALT;
        end else if (bus.load_use_d) begin
          bus.stall   = 1'b1;
          bus.flush_e = 1'b1;
        end
      end
      HALT: begin
        bus.stall   = 1'b1;
        bus.flush_d = 1'b1;
        if (bus.boot_req) state_nxt = BOOT;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Image write port, word counter and sticky status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt             <= '0;
      bus.imem_we      <= 1'b0;
      bus.imem_waddr   <= '0;
      bus.imem_wdata   <= 32'h0;
      bus.boot_done    <= 1'b0;
      bus.err_misalign <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      bus.imem_we <= accept;
      if (accept) begin
        bus.imem_waddr <= wcnt;
        bus.imem_wdata <= bus.ld_data;
        wcnt           <= wcnt + ADDR_W'(1);
        if ((wcnt == LAST_ADDR) && !bus.ld_last) bus.err_overflow <= 1'b1;
      end
      if (set_misalign) bus.err_misalign <= 1'b1;
      if (state == START) bus.boot_done <= 1'b1;
      if ((state == HALT) && bus.boot_req) begin
        wcnt             <= '0;
        bus.boot_done    <= 1'b0;
        bus.err_misalign <= 1'b0;
        bus.err_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with an 8-word image memory.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic        bt;
    logic [31:0] tg;
    logic        lu;
    logic        hr;
    logic        br;
  } in_t;

  typedef struct {
    logic        rdy;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic        ps;
    logic [31:0] pn;
    logic        fd;
    logic        fe;
    logic        bd;
    logic        em;
    logic        eo;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  fetch_ctrl_if #(.ADDR_W(3)) bus ();

  fetch_ctrl #(.IMEM_DEPTH(8), .ADDR_W(3), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mi(input logic lv, input logic [31:0] ld, input logic ll,
                             input logic bt, input logic [31:0] tg, input logic lu,
                             input logic hr, input logic br);
    in_t r;
    r.lv = lv; r.ld = ld; r.ll = ll; r.bt = bt; r.tg = tg; r.lu = lu; r.hr = hr; r.br = br;
    return r;
  endfunction

  function automatic exp_t me(input logic rdy, input logic we, input logic [2:0] wa,
                              input logic [31:0] wd, input logic st, input logic ps,
                              input logic [31:0] pn, input logic fd, input logic fe,
                              input logic bd, input logic em, input logic eo);
    exp_t r;
    r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd; r.st = st; r.ps = ps;
    r.pn = pn; r.fd = fd; r.fe = fe; r.bd = bd; r.em = em; r.eo = eo;
    return r;
  endfunction

  task automatic row(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    bus.ld_valid    = i.lv;
    bus.ld_data     = i.ld;
    bus.ld_last     = i.ll;
    bus.br_taken_e  = i.bt;
    bus.br_target_e = i.tg;
    bus.load_use_d  = i.lu;
    bus.halt_req    = i.hr;
    bus.boot_req    = i.br;
  endtask

  task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, r, act, want);
    end
  endtask

  task automatic check_all(input int r, input exp_t e);
    chk("ld_ready",     r, 32'(bus.ld_ready),     32'(e.rdy));
    chk("imem_we",      r, 32'(bus.imem_we),      32'(e.we));
    chk("imem_waddr",   r, 32'(bus.imem_waddr),   32'(e.wa));
    chk("imem_wdata",   r, bus.imem_wdata,        e.wd);
    chk("stall",        r, 32'(bus.stall),        32'(e.st));
    chk("pc_sel",       r, 32'(bus.pc_sel),       32'(e.ps));
    chk("pc_nxt",       r, bus.pc_nxt,            e.pn);
    chk("flush_d",      r, 32'(bus.flush_d),      32'(e.fd));
    chk("flush_e",      r, 32'(bus.flush_e),      32'(e.fe));
    chk("boot_done",    r, 32'(bus.boot_done),    32'(e.bd));
    chk("err_misalign", r, 32'(bus.err_misalign), 32'(e.em));
    chk("err_overflow", r, 32'(bus.err_overflow), 32'(e.eo));
  endtask

  initial begin
    exp_t rst_exp;
    checks = 0;
    errors = 0;
    rst_exp = me(Y, N, 3'd0, 32'h0, Y, N, RPC, N, N, N, N, N);

    // Four-word load with a gap, START, then run-mode hazards and halt.
    row(mi(Y, 32'h13,  N, N, 32'h0,  N, N, N), me(Y, N, 3'd0, 32'h0,   Y, N, RPC,    N, N, N, N, N));
    row(mi(Y, 32'h93,  N, N, 32'h0,  N, N, N), me(Y, Y, 3'd0, 32'h13,  Y, N, RPC,    N, N, N, N, N));
    row(mi(N, 32'h0,   N, N, 32'h0,  N, N, N), me(Y, Y, 3'd1, 32'h93,  Y, N, RPC,    N, N, N, N, N));
    row(mi(Y, 32'h113, N, N, 32'h0,  N, N, N), me(Y, N, 3'd1, 32'h93,  Y, N, RPC,    N, N, N, N, N));
    row(mi(Y, 32'h193, Y, N, 32'h0,  N, N, N), me(Y, Y, 3'd2, 32'h113, Y, N, RPC,    N, N, N, N, N));
    row(mi(N, 32'h0,   N, N, 32'h0,  N, N, N), me(N, Y, 3'd3, 32'h193, N, Y, RPC,    Y, Y, N, N, N));
    row(mi(N, 32'h0,   N, N, 32'h80, N, N, N), me(N, N, 3'd3, 32'h193, N, N, 32'h80, N, N, Y, N, N));
    row(mi(N, 32'h0,   N, Y, 32'h40, Y, N, N), me(N, N, 3'd3, 32'h193, N, Y, 32'h40, Y, Y, Y, N, N));
    row(mi(N, 32'h0,   N, N, 32'h0,  Y, N, N), me(N, N, 3'd3, 32'h193, Y, N, 32'h0,  N, Y, Y, N, N));
    row(mi(N, 32'h0,   N, N, 32'h0,  N, N, N), me(N, N, 3'd3, 32'h193, N, N, 32'h0,  N, N, Y, N, N));
    row(mi(N, 32'h0,   N, N, 32'h0,  Y, Y, N), me(N, N, 3'd3, 32'h193, Y, N, 32'h0,  Y, N, Y, N, N));
    row(mi(N, 32'h0,   N, Y, 32'h42, Y, N, N), me(N, N, 3'd3, 32'h193, Y, N, RPC,    Y, N, Y, N, N));
    row(mi(N, 32'h0,   N, N, 32'h0,  N, N, Y), me(N, N, 3'd3, 32'h193, Y, N, RPC,    Y, N, Y, N, N));
    // Overflowing image: ten words offered, eight accepted.
    for (int k = 0; k < 8; k++)
      row(mi(Y, 32'hA0 + 32'(k), N, N, 32'h0, N, N, N),
          me(Y, (k > 0) ? Y : N, (k > 0) ? 3'(k - 1) : 3'd3,
             (k > 0) ? 32'hA0 + 32'(k - 1) : 32'h193, Y, N, RPC, N, N, N, N, N));
    row(mi(Y, 32'hA8,  N, N, 32'h0,  N, N, N), me(N, Y, 3'd7, 32'hA7,  N, Y, RPC,    Y, Y, N, N, Y));
    row(mi(Y, 32'hA9,  N, N, 32'h0,  N, N, N), me(N, N, 3'd7, 32'hA7,  N, N, 32'h0,  N, N, Y, N, Y));
    row(mi(N, 32'h0,   N, Y, 32'h42, N, N, N), me(N, N, 3'd7, 32'hA7,  Y, N, 32'h42, Y, Y, Y, N, Y));
    row(mi(N, 32'h0,   N, N, 32'h0,  N, N, N), me(N, N, 3'd7, 32'hA7,  Y, N, RPC,    Y, N, Y, Y, Y));
    row(mi(N, 32'h0,   N, N, 32'h0,  N, N, Y), me(N, N, 3'd7, 32'hA7,  Y, N, RPC,    Y, N, Y, Y, Y));
    row(mi(Y, 32'h55,  N, N, 32'h0,  N, N, N), me(Y, N, 3'd7, 32'hA7,  Y, N, RPC,    N, N, N, N, N));
    row(mi(Y, 32'h66,  N, N, 32'h0,  N, N, N), me(Y, Y, 3'd0, 32'h55,  Y, N, RPC,    N, N, N, N, N));

    rst = 1'b0;
    drive(mi(N, 32'h0, N, N, 32'h0, N, N, N));
    repeat (2) @(negedge clk);
    check_all(-1, rst_exp);
    rst = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      drive(vecs[r].i);
      #1;
      check_all(r, vecs[r].e);
    end

    // Asynchronous reset in the middle of a load, away from any clock edge.
    @(negedge clk);
    drive(mi(N, 32'h0, N, N, 32'h0, N, N, N));
    #2 rst = 1'b0;
    #1 check_all(100, rst_exp);
    @(negedge clk);
    rst = 1'b1;

    // Fresh single-word image starts at address 0 and gives START next cycle.
    @(negedge clk);
    drive(mi(Y, 32'h77, Y, N, 32'h0, N, N, N));
    #1 check_all(101, rst_exp);
    @(negedge clk);
    drive(mi(N, 32'h0, N, N, 32'h0, N, N, N));
    #1 check_all(102, me(N, Y, 3'd0, 32'h77, N, Y, RPC, Y, Y, N, N, N));
    @(negedge clk);
    #1 check_all(103, me(N, N, 3'd0, 32'h77, N, N, 32'h0, N, N, Y, N, N));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. After reset it owns the instruction memory write port and streams a program image in from a loader, holding the PC in stall. It then releases the core from a clean redirect to the boot PC. In run mode it produces the fetch stage's stall, pc_sel, pc_nxt and the downstream flush strobes from branch, load-use and halt events.

## Interface
Parameters:
- IMEM_DEPTH, 1024: instruction memory size in 32-bit words.
- ADDR_W, 10: word-address width; must equal clog2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000: byte address fetched first after boot; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader presents a word.
- ld_data  in  32  instruction word.
- ld_last  in  1  qualifies the final word of the image.
- ld_ready  out  1  controller accepts loader words.
- imem_we  out  1  instruction memory write enable (registered).
- imem_waddr  out  ADDR_W  word write address (registered).
- imem_wdata  out  32  write data (registered).
- br_taken_e  in  1  execute stage resolves a taken branch or jump.
- br_target_e  in  32  byte target of that branch.
- load_use_d  in  1  decode detects a load-use hazard.
- halt_req  in  1  ecall/ebreak retired; stop fetching.
- boot_req  in  1  request a reload from HALT.
- stall  out  1  freeze PC and IF/ID.
- pc_sel  out  1  PC loads pc_nxt this edge.
- pc_nxt  out  32  redirect address.
- flush_d  out  1  bubble the IF/ID register.
- flush_e  out  1  bubble the ID/EX register.
- boot_done  out  1  image loaded, core running or halted.
- err_misalign  out  1  sticky flag for a misaligned branch target.
- err_overflow  out  1  sticky flag for an image longer than IMEM_DEPTH.

## Operation
- State machine has four states: BOOT, START, RUN, HALT. Reset enters BOOT.
- **BOOT**
  - ld_ready=1, stall=1, pc_sel=0, flush_d=flush_e=0.
  - Each accepted word (ld_valid&ld_ready) is registered onto imem_we/waddr/wdata for exactly one cycle. waddr comes from word counter wcnt, which then increments.
  - Leave to START when the accepted word has ld_last=1, or when wcnt==IMEM_DEPTH-1.
  - If the image ends at IMEM_DEPTH-1 without ld_last, set err_overflow; further loader words are not accepted.
- **START** (one cycle)
  - ld_ready=0, stall=0, pc_sel=1, pc_nxt=RESET_PC, flush_d=flush_e=1.
  - Next state is RUN; boot_done goes 1 from the next cycle.
- **RUN** (priority high to low)
  1. br_taken_e with br_target_e[1:0]!=0: set err_misalign, flush_d=flush_e=1, stall=1, go to HALT.
  2. br_taken_e: pc_sel=1, pc_nxt=br_target_e, flush_d=flush_e=1, stall=0. A coincident load_use_d is dropped, because the hazard instruction is flushed.
  3. halt_req: stall=1, flush_d=1, go to HALT.
  4. load_use_d: stall=1, flush_e=1, pc_sel=0.
  5. Otherwise all control outputs are 0.
- **HALT**
  - stall=1, flush_d=1, pc_sel=0, flush_e=0.
  - boot_req: clear wcnt and both error flags, clear boot_done, go to BOOT.
  - Other inputs are ignored.
- In RUN, pc_nxt=br_target_e whenever pc_sel=0; in other states it is RESET_PC.

## Timing
- RUN-state control outputs are combinational from the inputs and the state, so a redirect takes effect on the same edge.
- Output values during reset:
  - State BOOT, so ld_ready=1 and stall=1.
  - pc_sel, flush_d, flush_e, imem_we, imem_waddr, imem_wdata, boot_done, err_* are all 0.
  - pc_nxt=RESET_PC.
- Load latency: a word accepted at edge N appears on the imem write port during cycle N+1.
- A last word accepted at edge N gives START during cycle N+1 and RUN from N+2. The final imem write and START coincide.
- The loader may drop ld_valid between words; wcnt holds.
- Reset asserted mid-load or mid-run aborts immediately. The next boot starts at address 0.
- HALT→BOOT takes one cycle; ld_ready rises the cycle after boot_req is sampled.

## Test plan
- Load 4 words (0x13, 0x93, 0x113, 0x193), last on word 3 → four imem writes at waddr 0..3 on consecutive cycles. Then one START cycle with pc_sel=1, pc_nxt=0, flush_d=flush_e=1, then boot_done=1.
- RUN, br_taken_e=1 with target 0x40 and load_use_d=1 in the same cycle → pc_sel=1, pc_nxt=0x40, flush_d=flush_e=1, stall=0.
- RUN, load_use_d=1 for one cycle → stall=1, flush_e=1, pc_sel=0 for that cycle only.
- RUN, br_target_e=0x42 with br_taken_e → err_misalign=1, state HALT, stall=1 held.
- IMEM_DEPTH=8, stream 10 words without ld_last → 8 writes (waddr 0..7), err_overflow=1, ld_ready=0 after word 8, START follows.
- halt_req in RUN, then boot_req → BOOT, error flags cleared, next load starts at waddr 0. Asserting rst mid-load returns all outputs to their reset values asynchronously.
